fb_scanout: RTL and testbench

//  Upstream pixel source for the ILI9341 LCD driver. Fetches one RGB565 frame from framebuffer memory and buffers it in a FIFO.

---
 rtl/fb_scanout_pkg.sv | 15 +
 rtl/fb_scanout_if.sv | 24 ++
 rtl/fb_scanout_pix_fifo.sv | 53 +++++
 rtl/fb_scanout.sv | 131 +++++++++++++
 tb/tb_fb_scanout.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fb_scanout_pkg.sv
// rtl/fb_scanout_pkg.sv - shared LCD geometry, pixel type and scanout FSM encodings
package fb_scanout_pkg;

  localparam int LCD_H_RES = 240;
  localparam int LCD_V_RES = 320;
  localparam int RGB_W     = 16;

  typedef logic [RGB_W-1:0] rgb565_t;

  // Encodings are shared with the ILI9341 driver FSM.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

endpackage

// File: rtl/fb_scanout_if.sv
// rtl/fb_scanout_if.sv - framebuffer read port and driver pixel port bundle
interface fb_scanout_if #(
  parameter int ADDR_W = 17
) ();
  import fb_scanout_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  rgb565_t           mem_rdata;
  logic              pix_clk;
  rgb565_t           pix_data;

  modport master (
    output mem_req, mem_addr, pix_data,
    input  mem_ack, mem_rdata, pix_clk
  );

  modport slave (
    input  mem_req, mem_addr, pix_data,
    output mem_ack, mem_rdata, pix_clk
  );

endinterface

// File: rtl/fb_scanout_pix_fifo.sv
// rtl/fb_scanout_pix_fifo.sv - synchronous first-word-fall-through pixel FIFO
module fb_scanout_pix_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - TE-synchronised framebuffer fetch and pixel hand-off to the LCD driver
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int      H_RES       = LCD_H_RES,
  parameter int      V_RES       = LCD_V_RES,
  parameter int      ADDR_W      = 17,
  parameter int      FIFO_DEPTH  = 16,
  parameter rgb565_t UFLOW_COLOR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              lcd_fmark,
  fb_scanout_if.master      bus,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);
  localparam int TOTAL = H_RES * V_RES;
  localparam int CNT_W = ADDR_W + 1;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        state;
  logic              fm_meta, fm_sync, fm_prev;
  logic              fm_rise;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  fetch_cnt;
  logic [CNT_W-1:0]  pop_cnt;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              discard;

  rgb565_t           fifo_head;
  logic [FCW-1:0]    fifo_count;
  logic              fifo_empty, fifo_full;

  logic start, run, ack, accept, push, strobe, pop, last, issue;

  assign fm_rise = fm_sync && !fm_prev;
  assign run     = (state == ST_RUN);
  assign start   = (state == ST_WAIT_SYNC) && fm_rise;
  assign ack     = mem_req && bus.mem_ack;
  // Acks arriving outside RUN, or for a request left over from the previous frame, are dropped.
  assign accept  = ack && run && !discard;
  assign push    = accept && !fifo_full;
  assign strobe  = run && bus.pix_clk;
  assign pop     = strobe && !fifo_empty;
  assign last    = strobe && (pop_cnt == CNT_W'(TOTAL - 1));
  assign issue   = run && !mem_req && !last && (fetch_cnt < CNT_W'(TOTAL))
                   && (({1'b0, fifo_count} + 1'b1) <= (FCW+1)'(FIFO_DEPTH));

  assign busy         = (state == ST_WAIT_SYNC) || run;
  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = mem_addr;
  assign bus.pix_data = fifo_empty ? UFLOW_COLOR : fifo_head;

  fb_scanout_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RGB_W)
  ) u_pix_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (start),
    .wdata (bus.mem_rdata),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fm_meta    <= 1'b0;
      fm_sync    <= 1'b0;
      fm_prev    <= 1'b0;
      base       <= '0;
      fetch_cnt  <= '0;
      pop_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      discard    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      fm_meta    <= lcd_fmark;
      fm_sync    <= fm_meta;
      fm_prev    <= fm_sync;
      frame_done <= last;

      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_WAIT_SYNC;
        end
        ST_WAIT_SYNC: begin
          if (fm_rise) begin
            state     <= ST_RUN;
            base      <= fb_base;
            fetch_cnt <= '0;
            pop_cnt   <= '0;
            underrun  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) fetch_cnt <= fetch_cnt + 1'b1;
          if (strobe) begin
            pop_cnt <= pop_cnt + 1'b1;
            if (fifo_empty) underrun <= 1'b1;
          end
          if (last) state <= enable ? ST_WAIT_SYNC : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (issue) begin
        mem_req  <= 1'b1;
        mem_addr <= base + fetch_cnt[ADDR_W-1:0];
      end else if (ack) begin
        mem_req  <= 1'b0;
      end

      if (start && mem_req && !bus.mem_ack) discard <= 1'b1;
      else if (ack)                         discard <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - directed self-checking bench for fb_scanout
module tb_fb_scanout;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_scanout_if #(.ADDR_W(17)) bus_a ();
  fb_scanout_if #(.ADDR_W(17)) bus_b ();

  logic        en_a, en_b, fm_a, fm_b;
  logic [16:0] base_a, base_b;
  logic        busy_a, busy_b, done_a, done_b, ur_a, ur_b;

  fb_scanout #(.ADDR_W(17)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .enable     (en_a),
    .fb_base    (base_a),
    .lcd_fmark  (fm_a),
    .bus        (bus_a),
    .busy       (busy_a),
    .frame_done (done_a),
    .underrun   (ur_a)
  );

  fb_scanout #(.H_RES(4), .V_RES(2), .ADDR_W(17)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .enable     (en_b),
    .fb_base    (base_b),
    .lcd_fmark  (fm_b),
    .bus        (bus_b),
    .busy       (busy_b),
    .frame_done (done_b),
    .underrun   (ur_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int dly_a = 0, dly_b = 0, wait_a = 0, wait_b = 0, acks_a = 0, acks_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then run the memory responders.
  task automatic step();
    @(negedge clk);
    if (bus_a.mem_req && !bus_a.mem_ack) begin
      if (wait_a >= dly_a) begin
        bus_a.mem_ack = 1'b1; bus_a.mem_rdata = bus_a.mem_addr[15:0]; wait_a = 0; acks_a++;
      end else wait_a++;
    end else begin
      bus_a.mem_ack = 1'b0; wait_a = 0;
    end
    if (bus_b.mem_req && !bus_b.mem_ack) begin
      if (wait_b >= dly_b) begin
        bus_b.mem_ack = 1'b1; bus_b.mem_rdata = bus_b.mem_addr[15:0]; wait_b = 0; acks_b++;
      end else wait_b++;
    end else begin
      bus_b.mem_ack = 1'b0; wait_b = 0;
    end
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_a();
    fm_a = 1'b1; step(); fm_a = 1'b0;
  endtask

  task automatic pulse_b();
    fm_b = 1'b1; step(); fm_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en_a = 0; en_b = 0; fm_a = 0; fm_b = 0; base_a = '0; base_b = '0;
    bus_a.mem_ack = 0; bus_a.mem_rdata = '0; bus_a.pix_clk = 0;
    bus_b.mem_ack = 0; bus_b.mem_rdata = '0; bus_b.pix_clk = 0;

    // reset state
    step_n(2);
    rst = 1'b0;
    chk("rst_mem_req", bus_a.mem_req, 0);
    chk("rst_mem_addr", bus_a.mem_addr, 0);
    chk("rst_pix_data", bus_a.pix_data, 16'h0000);
    chk("rst_busy", busy_a, 0);
    chk("rst_frame_done", done_a, 0);
    chk("rst_underrun", ur_a, 0);
    step_n(3);
    chk("idle_no_req", bus_a.mem_req, 0);

    // enable, wait for TE, fill FIFO
    en_a = 1; base_a = 17'h100;
    step_n(5);
    chk("wait_sync_busy", busy_a, 1);
    chk("wait_sync_no_req", bus_a.mem_req, 0);
    pulse_a();
    step_n(2);
    chk("fm_latency_no_req", bus_a.mem_req, 0);
    step();
    chk("first_req", bus_a.mem_req, 1);
    chk("first_addr", bus_a.mem_addr, 17'h100);
    step();
    chk("req_gap", bus_a.mem_req, 0);
    step();
    chk("second_addr", bus_a.mem_addr, 17'h101);
    step_n(40);
    chk("fill_acks", acks_a, 16);
    chk("full_no_req", bus_a.mem_req, 0);
    chk("full_head", bus_a.pix_data, 16'h0100);
    step_n(10);
    chk("full_hold_acks", acks_a, 16);
    en_a = 0;

    // 4x2 frame, strobe every 4 cycles
    en_b = 1; base_b = 17'h100;
    step();
    pulse_b();
    step_n(3);
    for (int k = 0; k < 8; k++) begin
      step_n(3);
      chk($sformatf("seq_pix_%0d", k), bus_b.pix_data, 32'h100 + k);
      bus_b.pix_clk = 1; step(); bus_b.pix_clk = 0;
      chk($sformatf("seq_done_%0d", k), done_b, (k == 7) ? 1 : 0);
    end
    step();
    chk("done_single_pulse", done_b, 0);
    chk("back_wait_sync", busy_b, 1);
    chk("frame_acks", acks_b, 8);
    chk("frame_no_req", bus_b.mem_req, 0);
    chk("frame_empty_pix", bus_b.pix_data, 16'h0000);
    chk("frame_no_underrun", ur_b, 0);

    // starved frame
    dly_b = 20;
    pulse_b();
    step_n(3);
    chk("starve_req", bus_b.mem_req, 1);
    bus_b.pix_clk = 1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("starve_pix_%0d", i), bus_b.pix_data, 16'h0000);
      step();
      chk($sformatf("starve_done_%0d", i), done_b, (i == 8) ? 1 : 0);
    end
    bus_b.pix_clk = 0;
    chk("underrun_set", ur_b, 1);
    step_n(20);
    chk("late_ack_req_dropped", bus_b.mem_req, 0);
    chk("underrun_sticky", ur_b, 1);
    dly_b = 0;
    pulse_b();
    step_n(2);
    chk("underrun_cleared", ur_b, 0);
    dly_b = 60;
    step();
    chk("new_frame_req", bus_b.mem_req, 1);
    chk("new_frame_addr", bus_b.mem_addr, 17'h100);

    // reset mid-RUN with a request outstanding
    en_b = 0;
    rst = 1; step(); rst = 0;
    chk("midrst_req", bus_b.mem_req, 0);
    chk("midrst_busy", busy_b, 0);
    chk("midrst_pix", bus_b.pix_data, 16'h0000);
    pulse_b();
    step_n(10);
    chk("disabled_fm_no_req", bus_b.mem_req, 0);
    chk("disabled_fm_idle", busy_b, 0);

    // address wrap
    en_b = 1; base_b = 17'h1FFFE; dly_b = 0;
    step();
    pulse_b();
    step_n(3);
    chk("wrap_addr0", bus_b.mem_addr, 17'h1FFFE);
    step_n(2);
    chk("wrap_addr1", bus_b.mem_addr, 17'h1FFFF);
    step_n(2);
    chk("wrap_req2", bus_b.mem_req, 1);
    chk("wrap_addr2", bus_b.mem_addr, 17'h00000);
    step_n(5);
    chk("wrap_head", bus_b.pix_data, 16'hFFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
